// File: rtl/alu_rs_pkg.sv
// Shared sizing and types for the ALU reservation-station scheduler.
// The entry count sets the width of every per-entry vector and age-matrix row.
package alu_rs_pkg;

  localparam int unsigned RS_MSB     = 3;
  localparam int unsigned RS_ENTRIES = RS_MSB + 1;

  typedef logic [RS_ENTRIES-1:0] age_row_t;

endpackage : alu_rs_pkg

// File: rtl/rs_age_matrix.sv
// Age matrix for N station entries: older_q[i][j]=1 means entry i was allocated before entry j.
// It records allocation order and returns the oldest entry among a request vector.
module rs_age_matrix #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic [N-1:0] alloc_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] oldest_o
);

  logic [N-1:0] older_q [N];
  logic [N-1:0] older_d [N];

  // A newly allocated entry is younger than every other entry.
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      older_d[i] = older_q[i];
    end
    if (rst_i || flush_i) begin
      for (int i = 0; i < int'(N); i++) begin
        older_d[i] = '0;
      end
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        for (int j = 0; j < int'(N); j++) begin
          if (alloc_i[i]) begin
            older_d[i][j] = 1'b0;
          end else if (alloc_i[j]) begin
            older_d[i][j] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(N); i++) begin
      older_q[i] <= older_d[i];
    end
  end

  // An entry wins when it is older than every other requesting entry.
  always_comb begin
    oldest_o = '0;
    for (int i = 0; i < int'(N); i++) begin
      oldest_o[i] = req_i[i];
      for (int j = 0; j < int'(N); j++) begin
        if ((j != i) && req_i[j] && !older_q[i][j]) begin
          oldest_o[i] = 1'b0;
        end
      end
    end
  end

endmodule : rs_age_matrix

// File: rtl/alu_rs_scheduler.sv
// ALU reservation-station scheduler: lowest-free-entry allocation, dispatch stall,
// and oldest-ready issue select. Decisions are combinational; only the age matrix is stateful.
module alu_rs_scheduler
  import alu_rs_pkg::*;
#(
  parameter int unsigned RS = RS_MSB
) (
  input  logic        clk,
  input  logic        globalReset,
  input  logic        clear,
  input  logic        validCommit,
  input  logic        dispatchValid,
  input  logic [RS:0] busy,
  input  logic [RS:0] requests,
  input  logic        execute,
  output logic [RS:0] writeRequests,
  output logic [RS:0] grants,
  output logic        noSelect,
  output logic        dispatchStall
);

  localparam int unsigned N = RS + 1;

  logic        flush_c;
  logic        block_c;
  logic        all_busy_c;
  logic        alloc_en_c;
  logic        issue_en_c;
  logic [RS:0] free_c;
  logic [RS:0] lowest_free_c;
  logic [RS:0] valid_req_c;
  logic [RS:0] oldest_c;

  // A flush or reset suppresses every decision in the cycle it is seen.
  assign flush_c = clear & validCommit;
  assign block_c = flush_c | globalReset;

  // Allocation looks only at the busy flags presented this cycle, so an entry
  // being granted now is not reused until its busy flag actually drops.
  assign all_busy_c    = &busy;
  assign free_c        = ~busy;
  assign lowest_free_c = free_c & (~free_c + N'(1));

  assign dispatchStall = dispatchValid & all_busy_c & ~block_c;
  assign alloc_en_c    = dispatchValid & ~all_busy_c & ~block_c;
  assign writeRequests = alloc_en_c ? lowest_free_c : '0;

  // Requests from empty entries are stale and never considered.
  assign valid_req_c = requests & busy;
  assign issue_en_c  = execute & ~block_c;
  assign grants      = issue_en_c ? oldest_c : '0;
  assign noSelect    = ~|grants;

  rs_age_matrix #(
    .N(N)
  ) u_age_matrix (
    .clk      (clk),
    .rst_i    (globalReset),
    .flush_i  (flush_c),
    .alloc_i  (writeRequests),
    .req_i    (valid_req_c),
    .oldest_o (oldest_c)
  );

endmodule : alu_rs_scheduler

// File: tb/tb_alu_rs_scheduler.sv
// Directed bench for alu_rs_scheduler: each step queues its expected outputs,
// then pops and checks them against the DUT away from the clock edge.
module tb_alu_rs_scheduler;
  import alu_rs_pkg::*;

  typedef struct {
    string    tag;
    age_row_t wr;
    age_row_t gr;
    logic     ns;
    logic     st;
  } exp_t;

  logic     clk;
  logic     globalReset;
  logic     clear;
  logic     validCommit;
  logic     dispatchValid;
  age_row_t busy;
  age_row_t requests;
  logic     execute;
  age_row_t writeRequests;
  age_row_t grants;
  logic     noSelect;
  logic     dispatchStall;

  exp_t sb[$];
  int   checks;
  int   failures;

  alu_rs_scheduler #(.RS(RS_MSB)) dut (
    .clk           (clk),
    .globalReset   (globalReset),
    .clear         (clear),
    .validCommit   (validCommit),
    .dispatchValid (dispatchValid),
    .busy          (busy),
    .requests      (requests),
    .execute       (execute),
    .writeRequests (writeRequests),
    .grants        (grants),
    .noSelect      (noSelect),
    .dispatchStall (dispatchStall)
  );

  always #5 clk = ~clk;

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (writeRequests === e.wr) else begin
      failures++;
      $error("FAIL %s writeRequests observed=%b expected=%b", e.tag, writeRequests, e.wr);
    end
    checks++;
    assert (grants === e.gr) else begin
      failures++;
      $error("FAIL %s grants observed=%b expected=%b", e.tag, grants, e.gr);
    end
    checks++;
    assert (noSelect === e.ns) else begin
      failures++;
      $error("FAIL %s noSelect observed=%b expected=%b", e.tag, noSelect, e.ns);
    end
    checks++;
    assert (dispatchStall === e.st) else begin
      failures++;
      $error("FAIL %s dispatchStall observed=%b expected=%b", e.tag, dispatchStall, e.st);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic clr, input logic vc,
                      input logic dv, input age_row_t b, input age_row_t rq, input logic ex,
                      input age_row_t e_wr, input age_row_t e_gr, input logic e_ns,
                      input logic e_st);
    exp_t e;
    @(negedge clk);
    globalReset   = rst;
    clear         = clr;
    validCommit   = vc;
    dispatchValid = dv;
    busy          = b;
    requests      = rq;
    execute       = ex;
    e.tag = tag;
    e.wr  = e_wr;
    e.gr  = e_gr;
    e.ns  = e_ns;
    e.st  = e_st;
    sb.push_back(e);
    #1;
    check_out();
  endtask

  initial begin
    clk           = 1'b0;
    globalReset   = 1'b1;
    clear         = 1'b0;
    validCommit   = 1'b0;
    dispatchValid = 1'b0;
    busy          = '0;
    requests      = '0;
    execute       = 1'b0;
    checks        = 0;
    failures      = 0;

    //   tag                 rst clr vc dv busy     req      ex   wr       gr       ns    st
    step("reset",            1, 0, 0, 1, 4'b1111, 4'b1111, 1, 4'b0000, 4'b0000, 1'b1, 1'b0);
    step("alloc_first",      0, 0, 0, 1, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0000, 1'b1, 1'b0);
    step("reset_midop",      1, 0, 0, 1, 4'b0001, 4'b0001, 1, 4'b0000, 4'b0000, 1'b1, 1'b0);
    // Allocation order 2, 0, 3 (entry 1 held busy but never requests).
    step("alloc_e2",         0, 0, 0, 1, 4'b0011, 4'b0000, 0, 4'b0100, 4'b0000, 1'b1, 1'b0);
    step("alloc_e0",         0, 0, 0, 1, 4'b0110, 4'b0000, 0, 4'b0001, 4'b0000, 1'b1, 1'b0);
    step("alloc_e3",         0, 0, 0, 1, 4'b0111, 4'b0000, 0, 4'b1000, 4'b0000, 1'b1, 1'b0);
    step("grant_e2",         0, 0, 0, 0, 4'b1101, 4'b1101, 1, 4'b0000, 4'b0100, 1'b0, 1'b0);
    step("grant_e0",         0, 0, 0, 0, 4'b1001, 4'b1001, 1, 4'b0000, 4'b0001, 1'b0, 1'b0);
    step("grant_e3",         0, 0, 0, 0, 4'b1000, 4'b1000, 1, 4'b0000, 4'b1000, 1'b0, 1'b0);
    step("stall_full",       0, 0, 0, 1, 4'b1111, 4'b0000, 0, 4'b0000, 4'b0000, 1'b1, 1'b1);
    step("age_kept",         0, 0, 0, 0, 4'b1101, 4'b1101, 1, 4'b0000, 4'b0100, 1'b0, 1'b0);
    step("reset2",           1, 0, 0, 0, 4'b1101, 4'b1101, 1, 4'b0000, 4'b0000, 1'b1, 1'b0);
    // Allocation order 0, 1, 2, 3.
    step("fill_e0",          0, 0, 0, 1, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0000, 1'b1, 1'b0);
    step("fill_e1",          0, 0, 0, 1, 4'b0001, 4'b0000, 0, 4'b0010, 4'b0000, 1'b1, 1'b0);
    step("fill_e2",          0, 0, 0, 1, 4'b0011, 4'b0000, 0, 4'b0100, 4'b0000, 1'b1, 1'b0);
    step("fill_e3",          0, 0, 0, 1, 4'b0111, 4'b0000, 0, 4'b1000, 4'b0000, 1'b1, 1'b0);
    step("hold_exec0",       0, 0, 0, 1, 4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 1'b1, 1'b1);
    step("exec_oldest",      0, 0, 0, 0, 4'b1111, 4'b1111, 1, 4'b0000, 4'b0001, 1'b0, 1'b0);
    // Entry 2 freed: allocate it while entry 1 issues.
    step("alloc_and_grant",  0, 0, 0, 1, 4'b1011, 4'b0010, 1, 4'b0100, 4'b0010, 1'b0, 1'b0);
    step("new_youngest",     0, 0, 0, 0, 4'b1111, 4'b1100, 1, 4'b0000, 4'b1000, 1'b0, 1'b0);
    step("grant_keeps_age",  0, 0, 0, 0, 4'b1111, 4'b1111, 1, 4'b0000, 4'b0001, 1'b0, 1'b0);
    step("req_not_busy",     0, 0, 0, 0, 4'b1110, 4'b1111, 1, 4'b0000, 4'b0010, 1'b0, 1'b0);
    step("clear_no_commit",  0, 1, 0, 0, 4'b0011, 4'b0011, 1, 4'b0000, 4'b0001, 1'b0, 1'b0);
    step("flush",            0, 1, 1, 1, 4'b0011, 4'b0011, 1, 4'b0000, 4'b0000, 1'b1, 1'b0);
    // With an all-zero matrix no entry is older than another requester.
    step("matrix_zeroed",    0, 0, 0, 0, 4'b0011, 4'b0011, 1, 4'b0000, 4'b0000, 1'b1, 1'b0);
    step("single_req",       0, 0, 0, 0, 4'b0011, 4'b0010, 1, 4'b0000, 4'b0010, 1'b0, 1'b0);
    step("reset_busy",       1, 0, 0, 1, 4'b1111, 4'b1111, 1, 4'b0000, 4'b0000, 1'b1, 1'b0);
    step("post_reset_alloc", 0, 0, 0, 1, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0000, 1'b1, 1'b0);

    @(negedge clk);
    dispatchValid = 1'b0;
    execute       = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_alu_rs_scheduler

// File: doc/alu_rs_scheduler.md
ALU_RS_SCHEDULER -- requirements
Module: alu_rs_scheduler

Interface
REQ-001 SHALL have parameter: RS, default 3, MSB index of per-entry vectors (RS+1 = 4 entries).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: globalReset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: clear  input  1  misprediction flush qualifier.
REQ-005 SHALL have port: validCommit  input  1  flush taken only when clear & validCommit.
REQ-006 SHALL have port: dispatchValid  input  1  decode presents one ALU instruction this cycle.
REQ-007 SHALL have port: busy  input  RS+1  per-entry occupied flags from station entries.
REQ-008 SHALL have port: requests  input  RS+1  per-entry ready-for-select flags.
REQ-009 SHALL have port: execute  input  1  ALU accepts an instruction this cycle.
REQ-010 SHALL have port: writeRequests  output  RS+1  one-hot entry allocation (zero = none).
REQ-011 SHALL have port: grants  output  RS+1  one-hot issue grant (zero = none).
REQ-012 SHALL have port: noSelect  output  1  high when grants is zero.
REQ-013 SHALL have port: dispatchStall  output  1  dispatchValid & all entries busy.

Function
REQ-014 SHALL hold an (RS+1)x(RS+1) age matrix; older[i][j]=1 means entry i allocated before entry j; diagonal always 0.
REQ-015 SHALL allocate, when dispatchValid & ~dispatchStall & no flush & no reset, the lowest-index entry with busy=0; writeRequests one-hot on that bit, combinational, same cycle.
REQ-016 SHALL NOT allocate an entry freed by a grant in the same cycle; allocation uses current busy only.
REQ-017 SHALL on allocation to entry k at posedge: row k cleared to 0, column k set to 1 for every j!=k.
REQ-018 SHALL leave matrix unchanged in cycles with no allocation; grants never modify the matrix.
REQ-019 SHALL grant, when execute & no flush & no reset, the requesting entry i with older[i][j]=1 for every other requesting j (oldest ready); grants combinational, one-hot.
REQ-020 SHALL ignore requests bits whose busy bit is 0.
REQ-021 SHALL drive grants=0 and noSelect=1 when execute=0, no valid requests, flush, or reset.
REQ-022 SHALL permit allocation and grant in the same cycle to different entries; both occur.
REQ-023 SHALL assert dispatchStall combinationally when dispatchValid & busy all-ones; writeRequests=0 then.
REQ-024 SHALL on flush (clear & validCommit): writeRequests=0, grants=0, dispatchStall=0 that cycle; matrix cleared to 0 at posedge.
REQ-025 SHALL resolve flush and allocation in the same cycle in favour of flush.
REQ-026 SHALL add no latency: decisions visible in the cycle inputs are presented; only the matrix is registered.

Reset
REQ-027 SHALL clear the age matrix to all-zeros on any posedge with globalReset=1.
REQ-028 SHALL force writeRequests=0, grants=0, noSelect=1, dispatchStall=0 while globalReset=1.
REQ-029 SHALL take reset mid-operation (entries busy) with identical result; first post-reset allocation is entry 0 given busy=0.

Structure
REQ-030 SHALL place RS entry count and age-matrix row type in shared package alu_rs_pkg.
REQ-031 SHALL implement age tracking in one sub-module rs_age_matrix (alloc one-hot in, request vector in, oldest one-hot out); allocation encoder and stall logic stay in the top module.

Verification
REQ-032 SHALL cover: reset, busy=0000, dispatchValid=1 -> writeRequests=0001, dispatchStall=0.
REQ-033 SHALL cover: allocate entries 2,0,3 in successive cycles, all requesting, execute=1 -> grants 0100, then 0001, then 1000 as each deasserts.
REQ-034 SHALL cover: busy=1111, dispatchValid=1 -> dispatchStall=1, writeRequests=0000; matrix unchanged.
REQ-035 SHALL cover: busy=1011, grant to entry 1 (busy) and dispatch same cycle -> writeRequests=0100, grants=0010.
REQ-036 SHALL cover: clear=1, validCommit=1 with dispatchValid=1, requests=0011 -> writeRequests=0, grants=0, noSelect=1, matrix zero next cycle.
REQ-037 SHALL cover: execute=0, requests=1111 -> grants=0000, noSelect=1; execute=1 next cycle -> oldest entry granted.
